// File: rtl/reg_mem_lsu_pkg.sv
// Shared definitions for the register-file load/store sequencer:
// FSM state encodings, op codes and default bus widths.
package reg_mem_lsu_pkg;

  localparam int LSU_DATA_W  = 16;
  localparam int LSU_ADDR_W  = 16;
  localparam int LSU_TIMEOUT = 15;

  // State encodings kept as plain constants so legacy code can share them.
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ST_SEL = 3'd1;
  localparam logic [2:0] LD_REQ = 3'd2;
  localparam logic [2:0] ST_REQ = 3'd3;
  localparam logic [2:0] LD_WR  = 3'd4;

  // Operation codes carried on op_st.
  localparam logic OP_LD = 1'b0;
  localparam logic OP_ST = 1'b1;

  // True while a memory request is outstanding.
  function automatic logic is_req_state(input logic [2:0] s);
    return (s == LD_REQ) || (s == ST_REQ);
  endfunction

endpackage

// File: rtl/reg_mem_lsu_if.sv
// Request/acknowledge bus between the sequencer (master) and data memory (slave).
// req/we/addr/wdata are held by the master until the slave answers with ack;
// rdata is valid in the same cycle as ack.
interface reg_mem_lsu_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/reg_mem_lsu_wdog.sv
// Request watchdog: counts request cycles that pass without an acknowledge and
// flags the TIMEOUT-th one. Held at zero whenever no request is outstanding.
module reg_mem_lsu_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // The edge that would record the TIMEOUT-th unanswered cycle is the expiry edge.
  assign expire = en && (cnt == W'(TIMEOUT - 1));

  // Count unanswered request cycles; cleared outside the request states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/reg_mem_lsu.sv
// Load/store sequencer for the two-entry (X/Y) register file.
// Load:  memory read -> load/ldm/rw into the file's memory-load port.
// Store: select register via rw, wait for the file's registered out, write it to memory.
// Every output is a flop; a request with no ack for TIMEOUT cycles is aborted with err.
module reg_mem_lsu
  import reg_mem_lsu_pkg::*;
#(
  parameter int DATA_W  = LSU_DATA_W,
  parameter int ADDR_W  = LSU_ADDR_W,
  parameter int TIMEOUT = LSU_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_st,
  input  logic              sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] reg_out,
  reg_mem_lsu_if.master     mem,
  output logic              rw,
  output logic              ldm,
  output logic [DATA_W-1:0] load,
  output logic              busy,
  output logic              done,
  output logic              err
);

  logic [2:0] state;
  logic       sel_wait;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_expire;

  // Watchdog runs only while a request is outstanding and unanswered.
  assign wd_clr = !is_req_state(state);
  assign wd_en  = is_req_state(state) && !mem.ack;

  reg_mem_lsu_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (wd_clr),
    .en    (wd_en),
    .expire(wd_expire)
  );

  // Sequencer FSM; all outputs including the bus are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sel_wait  <= 1'b0;
      rw        <= 1'b0;
      ldm       <= 1'b0;
      load      <= '0;
      mem.req   <= 1'b0;
      mem.we    <= 1'b0;
      mem.addr  <= '0;
      mem.wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: done/err default low every edge so each can only be a one-cycle
      // pulse; all state here uses <= so every branch sees pre-edge values.
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rw       <= sel;
            mem.addr <= addr;
            busy     <= 1'b1;
            if (op_st == OP_ST) begin
              sel_wait <= 1'b0;
              state    <= ST_SEL;
            end else begin
              mem.req <= 1'b1;
              mem.we  <= 1'b0;
              state   <= LD_REQ;
            end
          end
        end
        ST_SEL: begin
          // The file's out follows rw one edge late, so capture on the second edge.
          if (sel_wait) begin
            mem.wdata <= reg_out;
            mem.req   <= 1'b1;
            mem.we    <= 1'b1;
            state     <= ST_REQ;
          end else begin
            sel_wait <= 1'b1;
          end
        end
        LD_REQ: begin
          // An ack on the expiry edge still completes the load.
          if (mem.ack) begin
            load    <= mem.rdata;
            ldm     <= 1'b1;
            mem.req <= 1'b0;
            state   <= LD_WR;
          end else if (wd_expire) begin
            mem.req <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end
        end
        ST_REQ: begin
          if (mem.ack) begin
            mem.req <= 1'b0;
            mem.we  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else if (wd_expire) begin
            mem.req <= 1'b0;
            mem.we  <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end
        end
        LD_WR: begin
          // The file takes load on this edge; ldm falls with it.
          ldm   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          mem.req <= 1'b0;
          mem.we  <= 1'b0;
          ldm     <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_mem_lsu.sv
// Directed bench for reg_mem_lsu with a behavioural X/Y register file and a
// data memory whose ack delay is programmable.
module tb_reg_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        op_st = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] reg_out = '0;
  logic        rw, ldm, busy, done, err;
  logic [15:0] load;

  reg_mem_lsu_if #(.DATA_W(16), .ADDR_W(16)) mem_bus ();

  // Memory model state.
  logic [15:0] mem [256];
  int          ack_delay = 0;
  int          wcnt = 0;
  logic        force_ack = 1'b0;
  logic        bd_we = 1'b0;
  logic [7:0]  bd_a = '0;
  logic [15:0] bd_d = '0;

  // Register file model.
  logic [15:0] fx = '0;
  logic [15:0] fy = '0;

  int compared = 0;
  int mismatched = 0;

  reg_mem_lsu #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(15)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_st  (op_st),
    .sel    (sel),
    .addr   (addr),
    .reg_out(reg_out),
    .mem    (mem_bus),
    .rw     (rw),
    .ldm    (ldm),
    .load   (load),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Ack after ack_delay unanswered request edges; force_ack injects a stray ack.
  assign mem_bus.ack   = (mem_bus.req && (wcnt == ack_delay)) || force_ack;
  assign mem_bus.rdata = mem[mem_bus.addr[7:0]];

  always @(posedge clk) begin
    if (!mem_bus.req || mem_bus.ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (bd_we) mem[bd_a] <= bd_d;
    else if (mem_bus.req && mem_bus.ack && mem_bus.we) mem[mem_bus.addr[7:0]] <= mem_bus.wdata;
  end

  always @(posedge clk) begin
    if (ldm) begin
      if (rw) fy <= load;
      else fx <= load;
    end
    reg_out <= rw ? fy : fx;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    bd_a = a;
    bd_d = d;
    bd_we = 1'b1;
    tick();
    bd_we = 1'b0;
  endtask

  // Launch one op and monitor it until done/err, plus one following cycle.
  task automatic run_op(input logic op, input logic s, input logic [15:0] a, input int d,
                        input logic [15:0] exp_wd, input bit restart,
                        output int n, output int busy_n, output int ldm_n, output int req_n,
                        output int done_n, output int err_n, output bit bus_bad);
    bit fin;
    ack_delay = d;
    op_st = op; sel = s; addr = a; start = 1'b1;
    n = 0; busy_n = 0; ldm_n = 0; req_n = 0; done_n = 0; err_n = 0; bus_bad = 1'b0; fin = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      op_st = ~op; sel = ~s; addr = ~a;
      start = restart && busy && (n % 2 == 1);
      if (busy) busy_n++;
      if (ldm) ldm_n++;
      if (mem_bus.req) begin
        req_n++;
        if (mem_bus.addr !== a || mem_bus.we !== op || (op && mem_bus.wdata !== exp_wd)) bus_bad = 1'b1;
      end
      if (done) done_n++;
      if (err) err_n++;
      if (done || err) begin
        fin = 1'b1;
        break;
      end
    end
    start = 1'b0;
    compared++;
    if (!fin) begin
      mismatched++;
      $display("FAIL op_finish: got no done/err within %0d cycles, expected one", n);
    end
    tick();
    if (busy) busy_n++;
    if (ldm) ldm_n++;
    if (mem_bus.req) req_n++;
    if (done) done_n++;
    if (err) err_n++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    compared++;
    if ({mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata, rw, ldm, load, busy, done, err} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got req=%b busy=%b done=%b err=%b ldm=%b rw=%b load=%h, expected all 0",
               mem_bus.req, busy, done, err, ldm, rw, load);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load();
    int n, b, l, r, dn, er;
    bit bad;
    preload(8'h10, 16'h1234);
    run_op(1'b0, 1'b0, 16'h0010, 0, 16'h0000, 1'b0, n, b, l, r, dn, er, bad);
    compared++;
    if (n !== 3) begin mismatched++; $display("FAIL load_latency: got %0d expected 3", n); end
    compared++;
    if (b !== 2) begin mismatched++; $display("FAIL load_busy_cycles: got %0d expected 2", b); end
    compared++;
    if (l !== 1 || r !== 1 || dn !== 1 || er !== 0 || bad) begin
      mismatched++;
      $display("FAIL load_pulses: got ldm=%0d req=%0d done=%0d err=%0d bad=%0b expected 1 1 1 0 0", l, r, dn, er, bad);
    end
    compared++;
    if (fx !== 16'h1234 || fy !== 16'h0000 || rw !== 1'b0) begin
      mismatched++;
      $display("FAIL load_file: got X=%h Y=%h rw=%b expected 1234 0000 0", fx, fy, rw);
    end
  endtask

  task automatic test_store();
    int n, b, l, r, dn, er;
    bit bad;
    preload(8'h50, 16'h00A5);
    run_op(1'b0, 1'b1, 16'h0050, 0, 16'h0000, 1'b0, n, b, l, r, dn, er, bad);
    compared++;
    if (fy !== 16'h00A5 || n !== 3) begin
      mismatched++;
      $display("FAIL store_preload_y: got Y=%h lat=%0d expected 00a5 3", fy, n);
    end
    run_op(1'b1, 1'b1, 16'h0020, 3, 16'h00A5, 1'b0, n, b, l, r, dn, er, bad);
    compared++;
    if (n !== 7 || b !== 6 || r !== 4) begin
      mismatched++;
      $display("FAIL store_timing: got lat=%0d busy=%0d req=%0d expected 7 6 4", n, b, r);
    end
    compared++;
    if (bad || l !== 0 || dn !== 1 || er !== 0) begin
      mismatched++;
      $display("FAIL store_bus: got bad=%0b ldm=%0d done=%0d err=%0d expected 0 0 1 0", bad, l, dn, er);
    end
    compared++;
    if (mem[8'h20] !== 16'h00A5) begin
      mismatched++;
      $display("FAIL store_mem: got %h expected 00a5", mem[8'h20]);
    end
  endtask

  task automatic test_timeout();
    int n, b, l, r, dn, er;
    bit bad;
    preload(8'h40, 16'hBEEF);
    run_op(1'b0, 1'b0, 16'h0040, 15, 16'h0000, 1'b0, n, b, l, r, dn, er, bad);
    compared++;
    if (n !== 16 || er !== 1 || dn !== 0) begin
      mismatched++;
      $display("FAIL timeout_abort: got lat=%0d err=%0d done=%0d expected 16 1 0", n, er, dn);
    end
    compared++;
    if (l !== 0 || r !== 15 || b !== 15 || fx !== 16'h1234 || fy !== 16'h00A5) begin
      mismatched++;
      $display("FAIL timeout_side: got ldm=%0d req=%0d busy=%0d X=%h Y=%h expected 0 15 15 1234 00a5",
               l, r, b, fx, fy);
    end
    run_op(1'b0, 1'b0, 16'h0040, 14, 16'h0000, 1'b0, n, b, l, r, dn, er, bad);
    compared++;
    if (n !== 17 || dn !== 1 || er !== 0 || l !== 1 || fx !== 16'hBEEF) begin
      mismatched++;
      $display("FAIL timeout_ack_last: got lat=%0d done=%0d err=%0d ldm=%0d X=%h expected 17 1 0 1 beef",
               n, dn, er, l, fx);
    end
  endtask

  task automatic test_ignore();
    int n, b, l, r, dn, er;
    int spur;
    bit bad;
    spur = 0;
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy || done || err || ldm || mem_bus.req) spur++;
    end
    force_ack = 1'b0;
    compared++;
    if (spur !== 0) begin mismatched++; $display("FAIL idle_ack: got %0d active cycles expected 0", spur); end
    run_op(1'b1, 1'b1, 16'h0070, 2, 16'h00A5, 1'b1, n, b, l, r, dn, er, bad);
    compared++;
    if (n !== 6 || dn !== 1 || bad || rw !== 1'b1) begin
      mismatched++;
      $display("FAIL busy_start: got lat=%0d done=%0d bad=%0b rw=%b expected 6 1 0 1", n, dn, bad, rw);
    end
    spur = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy || done || mem_bus.req) spur++;
    end
    compared++;
    if (spur !== 0 || mem[8'h70] !== 16'h00A5) begin
      mismatched++;
      $display("FAIL busy_start_after: got active=%0d mem=%h expected 0 00a5", spur, mem[8'h70]);
    end
  endtask

  task automatic test_reset_mid();
    int n, b, l, r, dn, er;
    bit bad;
    preload(8'h60, 16'h0000);
    ack_delay = 10;
    op_st = 1'b1; sel = 1'b0; addr = 16'h0060; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    compared++;
    if (mem_bus.req !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mid_pre: got req=%b busy=%b expected 1 1", mem_bus.req, busy);
    end
    rst = 1'b0;
    #2;
    compared++;
    if ({mem_bus.req, mem_bus.we, busy, done, err, ldm} !== 6'b0) begin
      mismatched++;
      $display("FAIL rst_mid_async: got req=%b we=%b busy=%b done=%b err=%b ldm=%b expected all 0",
               mem_bus.req, mem_bus.we, busy, done, err, ldm);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    compared++;
    if (mem[8'h60] !== 16'h0000 || fx !== 16'hBEEF) begin
      mismatched++;
      $display("FAIL rst_mid_nowrite: got mem=%h X=%h expected 0000 beef", mem[8'h60], fx);
    end
    run_op(1'b0, 1'b1, 16'h0010, 0, 16'h0000, 1'b0, n, b, l, r, dn, er, bad);
    compared++;
    if (n !== 3 || dn !== 1 || fy !== 16'h1234) begin
      mismatched++;
      $display("FAIL rst_mid_recover: got lat=%0d done=%0d Y=%h expected 3 1 1234", n, dn, fy);
    end
  endtask

  task automatic test_back_to_back();
    int n, b, l, r, dn, er;
    bit bad;
    run_op(1'b1, 1'b0, 16'h0030, 0, 16'hBEEF, 1'b0, n, b, l, r, dn, er, bad);
    compared++;
    if (n !== 4 || bad || mem[8'h30] !== 16'hBEEF || rw !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_store: got lat=%0d bad=%0b mem=%h rw=%b expected 4 0 beef 0", n, bad, mem[8'h30], rw);
    end
    run_op(1'b0, 1'b1, 16'h0030, 0, 16'h0000, 1'b0, n, b, l, r, dn, er, bad);
    compared++;
    if (n !== 3 || fy !== 16'hBEEF || fx !== 16'hBEEF || rw !== 1'b1 || load !== 16'hBEEF) begin
      mismatched++;
      $display("FAIL b2b_load: got lat=%0d Y=%h X=%h rw=%b load=%h expected 3 beef beef 1 beef",
               n, fy, fx, rw, load);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_watchdog: got no end of test by 200000 time units");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
